// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and constants for the SPI slave controller
package spi_pkg;
   localparam int DEF_WIDTH = 8;
   localparam logic RW_READ = 1'b1;
   typedef enum logic [2:0] {
      IDLE, GET_ADDR, GOT_ADDR, READ_LOAD, READ_SHIFT, WRITE_GET, WRITE_COMMIT, DONE
   } state_t;
endpackage

// File: rtl/spi_bit_counter.sv
// spi_bit_counter: saturating bit counter, flags the increment that completes a byte
module spi_bit_counter #(
   parameter int WIDTH = 8,
   parameter int CNTW = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_done
);
   localparam logic [CNTW-1:0] FULL = CNTW'(WIDTH);
   localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);
   logic [CNTW-1:0] r_cnt;
   assign o_done = i_inc && (r_cnt == LAST);
   // count enabled edges, hold at WIDTH, clear on request or reset
   always_ff @(posedge clk) begin
      if (!reset_n || i_clr) r_cnt <= '0;
      else if (i_inc && r_cnt != FULL) r_cnt <= r_cnt + 1'b1;
   end
endmodule

// File: rtl/spi_fsm.sv
// spi_fsm: SPI slave transaction sequencer driving address latch, load, write and MISO enable
module spi_fsm
   import spi_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNTW = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sclkPosEdge,
   input  logic sclkNegEdge,
   input  logic csN,
   input  logic rwBit,
   output logic addrWE,
   output logic srLoad,
   output logic dmWE,
   output logic misoBufe,
   output logic busy
);
   state_t r_state, w_next;
   logic w_inc, w_clr, w_done, w_cnt_st;
   logic r_addr_we, r_sr_load, r_dm_we, r_miso, r_busy;
   assign w_cnt_st = (r_state == GET_ADDR) || (r_state == WRITE_GET) || (r_state == READ_SHIFT);
   assign w_inc = (r_state == READ_SHIFT) ? sclkNegEdge : (w_cnt_st && sclkPosEdge);
   assign w_clr = csN || w_done || !w_cnt_st;
   spi_bit_counter #(.WIDTH(WIDTH), .CNTW(CNTW)) u_cnt (
      .clk(clk), .reset_n(reset_n), .i_clr(w_clr), .i_inc(w_inc), .o_done(w_done)
   );
   // next-state decode; chip select release overrides every state
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:         w_next = csN ? IDLE : GET_ADDR;
         GET_ADDR:     w_next = w_done ? GOT_ADDR : GET_ADDR;
         GOT_ADDR:     w_next = (rwBit == RW_READ) ? READ_LOAD : WRITE_GET;
         READ_LOAD:    w_next = READ_SHIFT;
         READ_SHIFT:   w_next = w_done ? DONE : READ_SHIFT;
         WRITE_GET:    w_next = w_done ? WRITE_COMMIT : WRITE_GET;
         WRITE_COMMIT: w_next = DONE;
         default:      w_next = DONE;
      endcase
      if (csN) w_next = IDLE;
   end
   // state register; outputs registered from the next state so they align with it
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_addr_we <= 1'b0;
         r_sr_load <= 1'b0;
         r_dm_we   <= 1'b0;
         r_miso    <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_addr_we <= w_next == GOT_ADDR;
         r_sr_load <= w_next == READ_LOAD;
         r_dm_we   <= w_next == WRITE_COMMIT;
         r_miso    <= w_next == READ_SHIFT;
         r_busy    <= w_next != IDLE;
      end
   end
   assign addrWE   = r_addr_we;
   assign srLoad   = r_sr_load;
   assign dmWE     = r_dm_we;
   assign misoBufe = r_miso;
   assign busy     = r_busy;
endmodule

// File: tb/tb_spi_fsm.sv
// tb_spi_fsm: directed scoreboard bench for the SPI transaction sequencer
module tb_spi_fsm;
   typedef struct {int kind; int cyc;} ev_t;
   logic clk = 1'b0, reset_n = 1'b0, sclkPosEdge = 1'b0, sclkNegEdge = 1'b0, csN = 1'b1, rwBit = 1'b0;
   logic addrWE, srLoad, dmWE, misoBufe, busy;
   int cyc = 0, checks = 0, errors = 0, miso_negs = 0;
   int cnt[3];
   bit miso_seen;
   ev_t q[$];
   spi_fsm dut (
      .clk(clk), .reset_n(reset_n), .sclkPosEdge(sclkPosEdge), .sclkNegEdge(sclkNegEdge),
      .csN(csN), .rwBit(rwBit), .addrWE(addrWE), .srLoad(srLoad), .dmWE(dmWE),
      .misoBufe(misoBufe), .busy(busy)
   );
   always #5 clk = ~clk;
   // cycle index used to timestamp strobes
   always @(posedge clk) cyc <= cyc + 1;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // strobe monitor: every strobe must match the head of the expected queue
   always @(negedge clk) begin
      logic [2:0] st;
      ev_t ev;
      st = {dmWE, srLoad, addrWE};
      for (int k = 0; k < 3; k++) begin
         if (st[k]) begin
            cnt[k]++;
            ev = (q.size() != 0) ? q.pop_front() : '{-1, -1};
            check("strobe kind", k, ev.kind);
            check("strobe cycle", cyc, ev.cyc);
         end
      end
      if (misoBufe) miso_seen = 1'b1;
      if (misoBufe && sclkNegEdge) miso_negs++;
   end
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic pulse(input logic p, input logic n);
      sclkPosEdge = p;
      sclkNegEdge = n;
      tick(1);
      sclkPosEdge = 1'b0;
      sclkNegEdge = 1'b0;
      tick(3);
   endtask
   task automatic expect_ev(input int k, input int d);
      q.push_back('{k, cyc + d});
   endtask
   task automatic clear_stats;
      cnt = '{default: 0};
      miso_seen = 1'b0;
      miso_negs = 0;
   endtask
   task automatic start;
      clear_stats();
      csN = 1'b0;
      tick(1);
      check("busy after cs low", busy, 1);
   endtask
   task automatic addr_phase(input logic [7:0] a, input int n, input logic stray);
      for (int i = 0; i < n; i++) begin
         rwBit = a[7-i];
         if (i == 7) begin
            expect_ev(0, 1);
            if (a[0]) expect_ev(1, 2);
         end
         pulse(1'b1, stray);
      end
   endtask
   task automatic finish_txn(input string tag);
      tick(3);
      check({tag, " busy in DONE"}, busy, 1);
      csN = 1'b1;
      tick(1);
      check({tag, " idle after cs high"}, busy, 0);
      check({tag, " queue drained"}, q.size(), 0);
   endtask
   task automatic read_txn(input string tag, input logic stray);
      start();
      addr_phase(8'h2B, 8, stray);
      check({tag, " misoBufe on"}, misoBufe, 1);
      for (int i = 0; i < 8; i++) pulse(stray, 1'b1);
      check({tag, " misoBufe off"}, misoBufe, 0);
      check({tag, " negedges shifted"}, miso_negs, 8);
      check({tag, " addrWE count"}, cnt[0], 1);
      check({tag, " srLoad count"}, cnt[1], 1);
      check({tag, " dmWE count"}, cnt[2], 0);
      finish_txn(tag);
   endtask
   initial begin
      logic [7:0] d;
      tick(3);
      check("reset addrWE", addrWE, 0);
      check("reset srLoad", srLoad, 0);
      check("reset dmWE", dmWE, 0);
      check("reset misoBufe", misoBufe, 0);
      check("reset busy", busy, 0);
      reset_n = 1'b1;
      tick(2);
      check("idle with cs high", busy, 0);
      read_txn("read", 1'b0);
      start();
      addr_phase(8'h2A, 8, 1'b0);
      d = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         rwBit = d[7-i];
         if (i == 7) expect_ev(2, 1);
         pulse(1'b1, 1'b0);
      end
      check("write addrWE count", cnt[0], 1);
      check("write srLoad count", cnt[1], 0);
      check("write dmWE count", cnt[2], 1);
      check("write misoBufe never", miso_seen, 0);
      finish_txn("write");
      start();
      addr_phase(8'h2B, 5, 1'b0);
      csN = 1'b1;
      tick(1);
      check("abort idle", busy, 0);
      tick(6);
      check("abort no addrWE", cnt[0], 0);
      check("abort no srLoad", cnt[1], 0);
      read_txn("after abort", 1'b0);
      start();
      addr_phase(8'h2B, 7, 1'b0);
      rwBit = 1'b1;
      sclkPosEdge = 1'b1;
      csN = 1'b1;
      tick(1);
      sclkPosEdge = 1'b0;
      check("race idle", busy, 0);
      tick(6);
      check("race no addrWE", cnt[0], 0);
      check("race no srLoad", cnt[1], 0);
      check("race queue", q.size(), 0);
      read_txn("stray edges", 1'b1);
      start();
      addr_phase(8'h2B, 8, 1'b0);
      for (int i = 0; i < 3; i++) pulse(1'b0, 1'b1);
      check("pre-reset misoBufe", misoBufe, 1);
      reset_n = 1'b0;
      tick(1);
      check("mid reset busy", busy, 0);
      check("mid reset misoBufe", misoBufe, 0);
      tick(1);
      check("reset held busy", busy, 0);
      check("reset held misoBufe", misoBufe, 0);
      check("reset held strobes", {addrWE, srLoad, dmWE}, 0);
      csN = 1'b1;
      reset_n = 1'b1;
      tick(2);
      check("post reset idle", busy, 0);
      check("post reset queue", q.size(), 0);
      read_txn("after reset", 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
